// File: rtl/imem_prog_loader_if.sv
// Stream-in handshake and imem write bus for the program loader.
// master = host/imem side, slave = loader.
interface imem_prog_loader_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_prog_loader.sv
// Instruction-memory program loader: streams words into consecutive imem addresses,
// holds the core in reset until the final write has landed, and keeps an additive checksum.
module imem_prog_loader #(
   parameter int                  ADDR_WIDTH = 10,
   parameter int                  DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   length,
   imem_prog_loader_if.slave     bus,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] checksum
);
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] MAX_LEN = DEPTH - {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t              state;
   logic [ADDR_WIDTH:0] count;
   logic [ADDR_WIDTH:0] len;
   logic                handshake;
   logic                last_word;
   logic                start_ok;

   always_comb begin
      bus.in_ready = (state == LOAD);
      busy         = (state == LOAD) || (state == FLUSH);
      handshake    = bus.in_valid && (state == LOAD);
      last_word    = (count == len - CNT_ONE);
      // Upper bound keeps BASE_ADDR + count inside the address space, so no wrap is possible.
      start_ok     = (length != '0) && (length <= MAX_LEN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= BASE_ADDR;
         bus.mem_wdata <= '0;
         cpu_reset     <= 1'b1;
         done          <= 1'b0;
         error         <= 1'b0;
         checksum      <= '0;
         count         <= '0;
         len           <= '0;
      end else begin
         done       <= 1'b0;
         error      <= 1'b0;
         bus.mem_we <= 1'b0;
         case (state)
            IDLE, RUN: begin
               if (start) begin
                  if (start_ok) begin
                     state     <= LOAD;
                     cpu_reset <= 1'b1;
                     count     <= '0;
                     checksum  <= '0;
                     len       <= length;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (handshake) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= BASE_ADDR + count[ADDR_WIDTH-1:0];
                  bus.mem_wdata <= bus.in_data;
                  checksum      <= checksum + bus.in_data;
                  count         <= count + CNT_ONE;
                  if (last_word) state <= FLUSH;
               end
            end
            // Final write is on the bus this cycle; the core is released only after it commits.
            FLUSH: begin
               state     <= RUN;
               cpu_reset <= 1'b0;
               done      <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
